// File: rtl/signed_mult8x8_final_adder.sv
// Two-stage pipelined carry-propagate adder resolving a Wallace-tree sum/carry pair
// into the final signed 16-bit product, with valid/ready flow control on both sides.
module signed_mult8x8_final_adder #(
  parameter int unsigned W     = 16,
  parameter int unsigned SPLIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] pp0,
  input  logic [W-1:0] pp1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         prod_zero
);

  localparam int unsigned HW = W - SPLIT;

  logic             r_s1_valid;
  logic             r_s1_c;
  logic [SPLIT-1:0] r_s1_lo;
  logic [HW-1:0]    r_s1_hi0;
  logic [HW-1:0]    r_s1_hi1;
  logic             r_out_valid;
  logic [W-1:0]     r_product;
  logic             r_prod_zero;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic [SPLIT:0]   w_lo_sum;
  logic [HW-1:0]    w_hi_sum;
  logic [W-1:0]     w_result;

  // Output register can take new data when empty or being drained this cycle.
  assign w_s2_adv = ~r_out_valid | out_ready;
  assign w_s1_adv = r_s1_valid & w_s2_adv;
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  // Lower slice with its carry-out, upper slice absorbs that carry a cycle later.
  assign w_lo_sum = {1'b0, pp0[SPLIT-1:0]} + {1'b0, pp1[SPLIT-1:0]};
  assign w_hi_sum = r_s1_hi0 + r_s1_hi1 + HW'(r_s1_c);
  assign w_result = {w_hi_sum, r_s1_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_c      <= 1'b0;
      r_s1_lo     <= '0;
      r_s1_hi0    <= '0;
      r_s1_hi1    <= '0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_prod_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_c     <= w_lo_sum[SPLIT];
        r_s1_lo    <= w_lo_sum[SPLIT-1:0];
        r_s1_hi0   <= pp0[W-1:SPLIT];
        r_s1_hi1   <= pp1[W-1:SPLIT];
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Carry out of the top bit is dropped; the tree already applied sign correction.
      if (w_s1_adv) begin
        r_product   <= w_result;
        r_prod_zero <= (w_result == '0);
        r_out_valid <= 1'b1;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign prod_zero = r_prod_zero;

endmodule
